// File: rtl/demux_14.sv
// Registered 1-to-4 demultiplexer: x is routed to lane sel on each rising edge,
// all other lanes are cleared. Reset clears every lane asynchronously.
module demux_14 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     x,
  input  logic [1:0]           sel,
  output logic [4*WIDTH-1:0]   y
);

  localparam int unsigned LANES = 4;

  // Each lane takes x only when its own index matches sel; unknown sel clears all lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        unique case (sel)
          2'd0, 2'd1, 2'd2, 2'd3:
            y[k*WIDTH +: WIDTH] <= (sel == 2'(k)) ? x : '0;
          default:
            y[k*WIDTH +: WIDTH] <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_14.sv
// Directed self-checking bench for demux_14 at WIDTH=1 and WIDTH=8.
module tb_demux_14;

  logic        clk;
  logic        rst;
  logic        x;
  logic [7:0]  x8;
  logic [1:0]  sel;
  logic [3:0]  y;
  logic [31:0] y8;

  int compared;
  int mismatched;

  demux_14 #(.WIDTH(1)) dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .sel (sel),
    .y   (y)
  );

  demux_14 #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .x   (x8),
    .sel (sel),
    .y   (y8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held with live inputs
    rst = 1'b1;
    x   = 1'b1;
    x8  = 8'hA5;
    sel = 2'd2;
    #1;
    check("reset_t0", 32'(y), 32'h0);
    check("reset_t0_w8", y8, 32'h0);
    tick();
    check("reset_edge1", 32'(y), 32'h0);
    tick();
    check("reset_edge2", 32'(y), 32'h0);
    check("reset_edge2_w8", y8, 32'h0);

    // Deassert between edges; first update at next rising edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_hold", 32'(y), 32'h0);
    tick();
    check("first_edge", 32'(y), 32'h4);
    check("first_edge_w8", y8, 32'h00A5_0000);

    // Lane sweep
    @(negedge clk);
    sel = 2'd0;
    #1;
    check("sweep_hold", 32'(y), 32'h4);
    tick();
    check("sweep_sel0", 32'(y), 32'h1);
    check("sweep_sel0_w8", y8, 32'h0000_00A5);
    @(negedge clk);
    sel = 2'd1;
    tick();
    check("sweep_sel1", 32'(y), 32'h2);
    check("sweep_sel1_w8", y8, 32'h0000_A500);
    @(negedge clk);
    sel = 2'd2;
    tick();
    check("sweep_sel2", 32'(y), 32'h4);
    @(negedge clk);
    sel = 2'd3;
    x8  = 8'h3C;
    tick();
    check("sweep_sel3", 32'(y), 32'h8);
    check("sweep_sel3_w8", y8, 32'h3C00_0000);

    // Zero data: x=1/sel=3 -> x=0 clears lane 3 one edge later
    @(negedge clk);
    x  = 1'b0;
    x8 = 8'h00;
    #1;
    check("zero_hold", 32'(y), 32'h8);
    tick();
    check("zero_sel3", 32'(y), 32'h0);
    check("zero_sel3_w8", y8, 32'h0);
    for (int s = 2; s >= 0; s--) begin
      @(negedge clk);
      sel = 2'(s);
      tick();
      check($sformatf("zero_sel%0d", s), 32'(y), 32'h0);
    end

    // Mid-cycle changes: only the value present at the edge matters
    @(negedge clk);
    x   = 1'b1;
    x8  = 8'h5A;
    sel = 2'd2;
    tick();
    check("mid_setup", 32'(y), 32'h4);
    @(negedge clk);
    sel = 2'd0;
    #1;
    check("mid_sel0", 32'(y), 32'h4);
    sel = 2'd1;
    #1;
    check("mid_sel1", 32'(y), 32'h4);
    sel = 2'd0;
    tick();
    check("mid_final", 32'(y), 32'h1);
    check("mid_final_w8", y8, 32'h0000_005A);

    // Async reset between edges
    @(negedge clk);
    sel = 2'd3;
    tick();
    check("async_setup", 32'(y), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", 32'(y), 32'h0);
    check("async_clear_w8", y8, 32'h0);
    tick();
    check("async_held", 32'(y), 32'h0);

    // Recovery: no state retained, next edge routes again
    @(negedge clk);
    rst = 1'b0;
    sel = 2'd1;
    #1;
    check("recover_hold", 32'(y), 32'h0);
    tick();
    check("recover_edge", 32'(y), 32'h2);
    check("recover_edge_w8", y8, 32'h0000_5A00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
